// File: rtl/seq_det_pkg.sv
// Shared types, reset defaults and helpers for the serial pattern-detect controller.
// The defaults reproduce the fixed 1101 overlapping Moore detector.
package seq_det_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [7:0]  DEF_PATTERN = 8'b0000_1101;
    localparam int unsigned DEF_LEN     = 4;
    localparam logic        DEF_OVERLAP = 1'b1;

    // A zero length would mask every bit and match on every shift, so it is promoted to 1.
    function automatic int unsigned len_clamp(input int unsigned len, input int unsigned pat_max);
        if (len == 0) begin
            return 1;
        end else if (len > pat_max) begin
            return pat_max;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/pattern_matcher.sv
// History shift register, fill counter and masked compare against the programmed pattern.
// Bit 0 of the history is the most recently shifted-in bit.
module pattern_matcher
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned LEN_W   = $clog2(PAT_MAX) + 1
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               shift_bit,
    input  logic               bit_en,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    input  logic               flush,
    output logic               match
);

    logic [PAT_MAX-1:0] hist_q, hist_d;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PAT_MAX; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end

        hist_d   = {hist_q[PAT_MAX-2:0], shift_bit};
        fill_inc = (fill_q >= LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : fill_q + LEN_W'(1);

        match = bit_en && ((hist_d & mask) == (pattern & mask)) && (fill_inc >= len);

        // Non-overlapping mode forgets the bits that formed the match.
        fill_d = fill_inc;
        if (match && !overlap) begin
            fill_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (flush) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (bit_en) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial pattern-detect controller: word handshake, MSB-first serialiser FSM, configuration
// registers, saturating match counter and sticky threshold interrupt.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   Cfg_we,
    input  logic [PAT_MAX-1:0]     Cfg_pattern,
    input  logic [$clog2(PAT_MAX):0] Cfg_len,
    input  logic                   Cfg_overlap,
    input  logic [CNT_W-1:0]       Cfg_thresh,
    input  logic                   In_valid,
    output logic                   In_ready,
    input  logic [DATA_W-1:0]      In_data,
    input  logic                   Clear,
    output logic                   Busy,
    output logic                   Match_pulse,
    output logic [CNT_W-1:0]       Match_count,
    output logic                   Irq
);

    localparam int unsigned LEN_W = $clog2(PAT_MAX) + 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;

    logic [PAT_MAX-1:0]  pattern_q;
    logic [LEN_W-1:0]    len_q;
    logic                overlap_q;
    logic [CNT_W-1:0]    thresh_q;

    logic [CNT_W-1:0]    count_q, count_d;
    logic                pulse_q;
    logic                irq_q, irq_d;

    logic                end_of_word;
    logic                handshake;
    logic                cfg_accept;
    logic                bit_en;
    logic                match;
    logic                clr;

    assign end_of_word = (state_q == SHIFT) && (bitcnt_q == '0);
    assign handshake   = In_valid && In_ready;
    assign cfg_accept  = Cfg_we && (state_q == IDLE);
    assign bit_en      = (state_q == SHIFT);
    assign Busy        = (state_q == SHIFT);

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        bitcnt_d = bitcnt_q;
        In_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                In_ready = !Cfg_we;
                if (In_valid && !Cfg_we) begin
                    sreg_d   = In_data;
                    bitcnt_d = BIT_W'(DATA_W - 1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d   = sreg_q << 1;
                bitcnt_d = bitcnt_q - BIT_W'(1);
                if (end_of_word) begin
                    // Reloading on the last bit keeps back-to-back words bubble-free.
                    In_ready = !Cfg_we;
                    if (In_valid && !Cfg_we) begin
                        sreg_d   = In_data;
                        bitcnt_d = BIT_W'(DATA_W - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pattern_q <= PAT_MAX'(DEF_PATTERN);
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            thresh_q  <= '0;
        end else if (cfg_accept) begin
            pattern_q <= Cfg_pattern;
            len_q     <= LEN_W'(len_clamp(32'(Cfg_len), PAT_MAX));
            overlap_q <= Cfg_overlap;
            thresh_q  <= Cfg_thresh;
        end
    end

    pattern_matcher #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .shift_bit (sreg_q[DATA_W-1]),
        .bit_en    (bit_en),
        .pattern   (pattern_q),
        .len       (len_q),
        .overlap   (overlap_q),
        .flush     (cfg_accept),
        .match     (match)
    );

    // Clear takes effect before a coincident match is counted.
    always_comb begin
        clr     = Clear || cfg_accept;
        count_d = clr ? '0 : count_q;
        irq_d   = clr ? 1'b0 : irq_q;
        if (match) begin
            if (count_d != '1) begin
                count_d = count_d + CNT_W'(1);
            end
            if ((thresh_q != '0) && (count_d == thresh_q)) begin
                irq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
            pulse_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pulse_q <= match;
            irq_q   <= irq_d;
        end
    end

    assign Match_pulse = pulse_q;
    assign Match_count = count_q;
    assign Irq         = irq_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: directed words push expected match events, a monitor
// pops and compares them whenever Match_pulse is seen.
module tb_seq_detect_ctrl;

    logic       Clock;
    logic       Reset_n;
    logic       Cfg_we;
    logic [7:0] Cfg_pattern;
    logic [3:0] Cfg_len;
    logic       Cfg_overlap;
    logic [7:0] Cfg_thresh;
    logic       In_valid;
    logic       In_ready;
    logic [7:0] In_data;
    logic       Clear;
    logic       Busy;
    logic       Match_pulse;
    logic [7:0] Match_count;
    logic       Irq;

    typedef struct {
        int unsigned cyc;
        int unsigned cnt;
        int unsigned irq;
    } exp_t;

    exp_t        expq[$];
    int unsigned cyc;
    int unsigned total;
    int unsigned bad;

    seq_detect_ctrl #(
        .DATA_W  (8),
        .PAT_MAX (8),
        .CNT_W   (8)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Cfg_we      (Cfg_we),
        .Cfg_pattern (Cfg_pattern),
        .Cfg_len     (Cfg_len),
        .Cfg_overlap (Cfg_overlap),
        .Cfg_thresh  (Cfg_thresh),
        .In_valid    (In_valid),
        .In_ready    (In_ready),
        .In_data     (In_data),
        .Clear       (Clear),
        .Busy        (Busy),
        .Match_pulse (Match_pulse),
        .Match_count (Match_count),
        .Irq         (Irq)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int unsigned c, input int unsigned n, input int unsigned i);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        e.irq = i;
        expq.push_back(e);
    endfunction

    // Monitor: every observed pulse must match the oldest outstanding expectation.
    always @(negedge Clock) begin : monitor
        exp_t e;
        if (Reset_n && Match_pulse) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: pulse at cycle %0d count %0d, none expected",
                         cyc, Match_count);
            end else begin
                e = expq.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_count", 32'(Match_count), e.cnt);
                check("pulse_irq", 32'(Irq), e.irq);
            end
        end
    end

    // Returns just after the accept edge; acc is the edge index at which the word was taken.
    task automatic send(input logic [7:0] d, input bit hold, output int unsigned acc);
        bit got;
        got      = 1'b0;
        acc      = 0;
        In_valid = 1'b1;
        In_data  = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clock);
            if (In_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("accept_timeout", 0, 1);
        end else begin
            acc = cyc + 1;
            @(posedge Clock);
            #1;
        end
        if (!hold) In_valid = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                       input logic [7:0] th);
        Cfg_pattern = pat;
        Cfg_len     = len;
        Cfg_overlap = ov;
        Cfg_thresh  = th;
        Cfg_we      = 1'b1;
        @(posedge Clock);
        #1;
        Cfg_we = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clock);
            if (!Busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) check("idle_timeout", 0, 1);
        @(posedge Clock);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned a, a1, a2;
        total       = 0;
        bad         = 0;
        Reset_n     = 1'b1;
        Cfg_we      = 1'b0;
        Cfg_pattern = '0;
        Cfg_len     = '0;
        Cfg_overlap = 1'b0;
        Cfg_thresh  = '0;
        In_valid    = 1'b0;
        In_data     = '0;
        Clear       = 1'b0;
        #2 Reset_n = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_ready", 32'(In_ready), 1);
        check("rst_busy", 32'(Busy), 0);
        check("rst_pulse", 32'(Match_pulse), 0);
        check("rst_count", 32'(Match_count), 0);
        check("rst_irq", 32'(Irq), 0);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;

        // Default 1101 overlapping: 11011011 matches at bits 3 and 6.
        send(8'hDB, 1'b0, a);
        push(a + 4, 1, 0);
        push(a + 7, 2, 0);
        @(negedge Clock);
        check("busy_shift", 32'(Busy), 1);
        wait_idle();
        check("default_count", 32'(Match_count), 2);

        // Config write with a word pending: write wins, ready low, count cleared.
        Cfg_pattern = 8'h0D;
        Cfg_len     = 4'd4;
        Cfg_overlap = 1'b0;
        Cfg_thresh  = 8'd0;
        Cfg_we      = 1'b1;
        In_valid    = 1'b1;
        In_data     = 8'hDB;
        @(negedge Clock);
        check("ready_during_cfg", 32'(In_ready), 0);
        @(posedge Clock);
        #1;
        Cfg_we = 1'b0;
        check("cfg_clears_count", 32'(Match_count), 0);
        send(8'hDB, 1'b0, a);
        push(a + 4, 1, 0);
        wait_idle();
        check("nonoverlap_count", 32'(Match_count), 1);

        // Match spanning a word boundary, words back-to-back.
        cfg(8'h0D, 4'd4, 1'b1, 8'd0);
        send(8'h01, 1'b1, a1);
        send(8'hA0, 1'b0, a2);
        check("no_bubble", a2 - a1, 8);
        push(a2 + 3, 1, 0);
        wait_idle();
        check("boundary_count", 32'(Match_count), 1);

        // Threshold 3 over two words.
        cfg(8'h0D, 4'd4, 1'b1, 8'd3);
        send(8'hDB, 1'b1, a1);
        push(a1 + 4, 1, 0);
        push(a1 + 7, 2, 0);
        send(8'hDB, 1'b0, a2);
        push(a2 + 4, 3, 1);
        push(a2 + 7, 4, 1);
        wait_idle();
        check("irq_sticky", 32'(Irq), 1);
        check("thresh_count", 32'(Match_count), 4);
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        Clear = 1'b0;
        check("clear_count", 32'(Match_count), 0);
        check("clear_irq", 32'(Irq), 0);

        // Clear held during the cycle of the second match: count restarts at 1.
        send(8'hDB, 1'b0, a);
        push(a + 4, 1, 0);
        push(a + 7, 1, 0);
        repeat (6) @(posedge Clock);
        #1;
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        Clear = 1'b0;
        wait_idle();
        check("clear_coincident_count", 32'(Match_count), 1);

        // Length 0 acts as length 1: pattern 1 on 01010101 gives four matches.
        cfg(8'h01, 4'd0, 1'b1, 8'd0);
        send(8'h55, 1'b0, a);
        push(a + 2, 1, 0);
        push(a + 4, 2, 0);
        push(a + 6, 3, 0);
        push(a + 8, 4, 0);
        wait_idle();
        check("len0_count", 32'(Match_count), 4);

        // Saturation: 33 words of ones, 264 matches, count pinned at 255.
        cfg(8'h01, 4'd1, 1'b1, 8'd0);
        for (int w = 0; w < 33; w++) begin
            send(8'hFF, (w != 32), a);
            for (int k = 0; k < 8; k++) begin
                push(a + k + 1, ((8 * w + k + 1) > 255) ? 255 : (8 * w + k + 1), 0);
            end
        end
        wait_idle();
        check("sat_count", 32'(Match_count), 255);

        // Config write while shifting is ignored.
        send(8'h00, 1'b0, a);
        Cfg_pattern = 8'h0D;
        Cfg_len     = 4'd4;
        Cfg_overlap = 1'b0;
        Cfg_thresh  = 8'd5;
        Cfg_we      = 1'b1;
        @(posedge Clock);
        #1;
        Cfg_we = 1'b0;
        wait_idle();
        check("cfg_in_shift_count", 32'(Match_count), 255);
        send(8'hFF, 1'b0, a);
        for (int k = 0; k < 8; k++) push(a + k + 1, 255, 0);
        wait_idle();

        // Reset mid-word.
        send(8'hFF, 1'b0, a);
        push(a + 1, 255, 0);
        push(a + 2, 255, 0);
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        #1;
        Reset_n = 1'b0;
        #1;
        check("midrst_ready", 32'(In_ready), 1);
        check("midrst_busy", 32'(Busy), 0);
        check("midrst_pulse", 32'(Match_pulse), 0);
        check("midrst_count", 32'(Match_count), 0);
        check("midrst_irq", 32'(Irq), 0);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        send(8'hDB, 1'b0, a);
        push(a + 4, 1, 0);
        push(a + 7, 2, 0);
        wait_idle();
        check("post_rst_count", 32'(Match_count), 2);
        repeat (2) @(posedge Clock);
        check("pending_expect", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Configurable serial pattern-detect controller.
- Accepts parallel bytes over a valid/ready handshake and serialises them MSB-first into a history shift register.
- Compares the history against a programmable pattern (length 1..PAT_MAX, overlapping or non-overlapping) and counts matches, with a threshold interrupt.
- Its reset configuration reproduces the team's fixed 1101 overlapping Moore detector, so it can replace that detector as a bit-stream front end.

Parameters:
- DATA_W, 8: input word width, serialised MSB-first.
- PAT_MAX, 8: maximum pattern length in bits.
- CNT_W, 8: match counter width.

Ports:
- Clock  input  1  single clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Cfg_we  input  1  config write strobe.
- Cfg_pattern  input  PAT_MAX  pattern; bit 0 is the most recent bit.
- Cfg_len  input  $clog2(PAT_MAX)+1  pattern length.
- Cfg_overlap  input  1  1 = overlapping detection.
- Cfg_thresh  input  CNT_W  interrupt threshold; 0 disables the interrupt.
- In_valid  input  1  input word valid.
- In_ready  output  1  controller can accept a word.
- In_data  input  DATA_W  input word.
- Clear  input  1  clears Match_count and Irq.
- Busy  output  1  serialisation in progress.
- Match_pulse  output  1  one-cycle pulse per detected match.
- Match_count  output  CNT_W  saturating match count.
- Irq  output  1  sticky threshold interrupt.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State IDLE.
  - History, fill counter and bit counter are 0.
  - Pattern = 4'b1101 zero-extended, len = 4, overlap = 1, thresh = 0.
  - Outputs: In_ready=1, Busy=0, Match_pulse=0, Match_count=0, Irq=0.
- Reset mid-word: the partial word is discarded and no pulse is generated.
- FSM states are IDLE and SHIFT.
- IDLE:
  - In_ready = !Cfg_we.
  - An In_valid&&In_ready handshake loads In_data into the shift register, sets bitcnt = DATA_W-1 and moves to SHIFT.
- SHIFT, one cycle per bit:
  - hist <= {hist[PAT_MAX-2:0], sreg[DATA_W-1]}; sreg shifts left.
  - fill <= min(fill+1, PAT_MAX).
  - bitcnt decrements.
- End of word (SHIFT with bitcnt==0):
  - In_ready = !Cfg_we.
  - A handshake in this cycle reloads the shift register and stays in SHIFT, giving back-to-back words with no bubble (DATA_W cycles per word).
  - Otherwise the FSM returns to IDLE.
- Busy = (state==SHIFT).
- Match condition, evaluated on the updated history:
  - (hist_next & mask) == (pattern & mask) and fill_next >= len, where mask = low len bits.
- Match timing: Match_pulse, Match_count and Irq are registered at the same edge that shifts in the completing bit. Bit k of a word (k=0 is the MSB) is shifted in at the (k+1)-th edge after the accept edge.
- On a match:
  - If Cfg_overlap=0, fill_next is forced to 0, so matched bits are not reused.
  - If Cfg_overlap=1, fill is unchanged.
- History persists across word boundaries and across IDLE gaps. It is cleared only by reset or Cfg_we.
- Match_count:
  - Increments by 1 per match and saturates at 2^CNT_W-1.
  - Match_pulse still fires while the count is saturated.
- Irq:
  - Set when thresh != 0 and the count value after the update equals thresh.
  - Stays set until Clear, Cfg_we or reset.
- Clear in the same cycle as a match: Clear is applied first, so Match_count=1. Irq is then set only if thresh==1.
- Config writes:
  - Cfg_we is accepted only when Busy=0. In SHIFT it is ignored with no effect.
  - An accepted write latches pattern, len, overlap and thresh, and clears hist, fill, Match_count and Irq.
  - Cfg_we has priority over a handshake: In_ready is deasserted in that cycle.
  - Cfg_len=0 is treated as 1; Cfg_len>PAT_MAX is clamped to PAT_MAX.
- In_data must be held stable while In_valid=1 and In_ready=0.

Decomposition:
- Package seq_det_pkg holds:
  - the state_t enum {IDLE, SHIFT};
  - the constants DEF_PATTERN=8'b0000_1101, DEF_LEN=4, DEF_OVERLAP=1;
  - the function len_clamp().
- Sub-module pattern_matcher holds the history shift register, fill counter and masked compare.
  - Inputs: bit, bit_en, pattern, len, overlap, flush.
  - Output: match.
  - The top level keeps the FSM, handshake, configuration registers, counter and Irq.

Test Plan:
- Default configuration, send 0xDB (11011011) -> 2 Match_pulses, at the 4th and 7th shift edges; Match_count=2; one word takes 8 cycles.
- Cfg overlap=0 (pattern 1101, len 4), send 0xDB -> exactly 1 pulse, at the 4th edge; Match_count=1.
- Cross-boundary: send 0x01 then 0xA0 back-to-back -> In_ready high at the end-of-word cycle, no bubble, 1 pulse at the 3rd bit of the second word.
- Threshold:
  - Cfg thresh=3, send 0xDB, 0xDB -> Irq rises with the 3rd match and stays high.
  - Clear -> Match_count=0, Irq=0.
  - Clear coincident with a match -> Match_count=1.
- Saturation: CNT_W=8, pattern 1 with len=1, feed 0xFF words -> count stops at 255, Match_pulse keeps firing.
- Config and reset corner cases:
  - Cfg_we during SHIFT -> ignored.
  - Cfg_we with In_valid in IDLE -> In_ready=0 and the write is applied.
  - Cfg_len=0 -> behaves as len 1.
  - Reset_n low mid-word -> all outputs reset immediately and the default pattern is restored.
